// File: rtl/stim_gen.sv
// Stimulus generator: four operand patterns issued one vector per clock, with a drain phase before done.
// Optional build macro STIM_HALT_ON_EVENT_EN makes a monitor mismatch pulse stop the run.
module stim_gen #(
  parameter int          WIDTH        = 32,
  parameter logic [31:0] SEED_A       = 32'hACE12468,
  parameter logic [31:0] SEED_B       = 32'h1357BDF0,
  parameter int          DRAIN_CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [1:0]       i_mode,
  input  logic [31:0]      i_count,
  input  logic             i_event,
  output logic [WIDTH-1:0] o_dut_ia,
  output logic [WIDTH-1:0] o_dut_ib,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic [31:0]      o_vec_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state;
  state_t      next_state;
  logic        done_seen;
  logic [1:0]  mode_q;
  logic [31:0] count_q;
  logic [31:0] k;
  logic [31:0] vec_cnt;
  logic [31:0] drain_cnt;
  logic [31:0] lfsr_a;
  logic [31:0] lfsr_b;
  logic        halt;
  logic        start_ok;
  logic        stop_run;
  logic        issue;
  logic        drain_end;
  logic [31:0] idx;
  logic [1:0]  mode_sel;
  logic [31:0] vec_a;
  logic [31:0] vec_b;

  // Galois form of x^32+x^22+x^2+x+1, shifting toward bit 0
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
  endfunction

  function automatic logic [31:0] corner(input logic [2:0] sel);
    case (sel)
      3'd0:    return 32'h00000000;
      3'd1:    return 32'h00000001;
      3'd2:    return 32'h7FFFFFFF;
      3'd3:    return 32'h80000000;
      3'd4:    return 32'hFFFFFFFF;
      3'd5:    return 32'hFFFFFFFE;
      3'd6:    return 32'h55555555;
      default: return 32'hAAAAAAAA;
    endcase
  endfunction

`ifdef STIM_HALT_ON_EVENT_EN
  assign halt = i_event;
`else
  logic unused_event;
  assign unused_event = i_event;
  assign halt         = 1'b0;
`endif

  assign start_ok  = i_start && !i_stop && (state == IDLE || state == DONE);
  assign stop_run  = (state == RUN) &&
                     (i_stop || halt || (count_q != 32'd0 && vec_cnt == count_q));
  assign issue     = start_ok || (state == RUN && !stop_run);
  assign drain_end = (drain_cnt == 32'(DRAIN_CYCLES - 1));

  // The start edge issues vector 0 with the freshly sampled mode
  assign idx      = start_ok ? 32'd0 : k;
  assign mode_sel = start_ok ? i_mode : mode_q;

  always_comb begin
    vec_a = lfsr_a;
    vec_b = lfsr_b;
    case (mode_sel)
      2'd1: begin
        vec_a = corner(idx[5:3]);
        vec_b = corner(idx[2:0]);
      end
      2'd2: begin
        vec_a = idx;
        vec_b = ~idx;
      end
      2'd3: begin
        vec_a = 32'd1 << idx[4:0];
        vec_b = 32'd1 << (idx[4:0] + 5'd1);
      end
      default: begin
        vec_a = lfsr_a;
        vec_b = lfsr_b;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      done_seen <= 1'b0;
    end else begin
      state     <= next_state;
      done_seen <= (state == DONE);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (start_ok) next_state = RUN;
      RUN:        if (stop_run) next_state = DRAIN;
      DRAIN:      if (drain_end) next_state = DONE;
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    o_valid = (state == RUN);
    o_busy  = (state == RUN) || (state == DRAIN);
    o_done  = (state == DONE) && !done_seen;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_dut_ia  <= '0;
      o_dut_ib  <= '0;
      lfsr_a    <= SEED_A;
      lfsr_b    <= SEED_B;
      k         <= 32'd0;
      vec_cnt   <= 32'd0;
      mode_q    <= 2'd0;
      count_q   <= 32'd0;
      drain_cnt <= 32'd0;
    end else begin
      if (start_ok) begin
        mode_q  <= i_mode;
        count_q <= i_count;
      end
      if (issue) begin
        o_dut_ia <= vec_a;
        o_dut_ib <= vec_b;
        k        <= idx + 32'd1;
        if (start_ok)
          vec_cnt <= 32'd1;
        else if (vec_cnt != 32'hFFFFFFFF)
          vec_cnt <= vec_cnt + 32'd1;
        if (mode_sel == 2'd0) begin
          lfsr_a <= lfsr_step(lfsr_a);
          lfsr_b <= lfsr_step(lfsr_b);
        end
      end
      if (stop_run)
        drain_cnt <= 32'd0;
      else if (state == DRAIN)
        drain_cnt <= drain_cnt + 32'd1;
    end
  end

  assign o_vec_cnt = vec_cnt;

endmodule

// File: tb/tb_stim_gen.sv
// Directed bench for stim_gen: reset, all four patterns, stop/abort paths and done timing.
module tb_stim_gen;
  localparam logic [31:0] SA = 32'hACE12468;
  localparam logic [31:0] SB = 32'h1357BDF0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic [1:0]  i_mode = 2'd0;
  logic [31:0] i_count = 32'd0;
  logic        i_event = 1'b0;
  logic [31:0] o_dut_ia, o_dut_ib, o_vec_cnt;
  logic        o_valid, o_busy, o_done;

  int tests = 0;
  int fails = 0;

  logic [31:0] tbl [8] = '{32'h00000000, 32'h00000001, 32'h7FFFFFFF, 32'h80000000,
                          32'hFFFFFFFF, 32'hFFFFFFFE, 32'h55555555, 32'hAAAAAAAA};

  stim_gen #(.WIDTH(32), .SEED_A(SA), .SEED_B(SB), .DRAIN_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_stop(i_stop), .i_mode(i_mode),
    .i_count(i_count), .i_event(i_event), .o_dut_ia(o_dut_ia), .o_dut_ib(o_dut_ib),
    .o_valid(o_valid), .o_busy(o_busy), .o_done(o_done), .o_vec_cnt(o_vec_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_lfsr(input logic [31:0] s);
    logic [31:0] r;
    r = {1'b0, s[31:1]};
    if (s[0]) r = r ^ 32'h80200003;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run(input logic [1:0] m, input logic [31:0] c);
    i_mode  = m;
    i_count = c;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Steps until o_done; expects it exactly want_n cycles from the current one
  task automatic wait_done(input int want_n, input string name);
    int  n;
    bit  seen;
    bit  bad_valid;
    n = 0;
    seen = 0;
    bad_valid = 0;
    for (int i = 1; i <= want_n + 4 && !seen; i++) begin
      tick();
      if (o_valid !== 1'b0) bad_valid = 1;
      if (o_done === 1'b1) begin
        seen = 1;
        n = i;
      end
    end
    tests++;
    if (!seen || n != want_n) begin
      fails++;
      $display("FAIL %s done_latency got %0d want %0d", name, n, want_n);
    end
    tests++;
    if (o_busy !== 1'b0) begin
      fails++;
      $display("FAIL %s busy_at_done got %b want 0", name, o_busy);
    end
    tests++;
    if (bad_valid) begin
      fails++;
      $display("FAIL %s valid_after_run got 1 want 0", name);
    end
    tick();
    tests++;
    if (o_done !== 1'b0) begin
      fails++;
      $display("FAIL %s done_pulse_width got %b want 0", name, o_done);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #10;
    tests++;
    if ({o_valid, o_busy, o_done} !== 3'b000 || o_dut_ia !== 32'd0 || o_dut_ib !== 32'd0
        || o_vec_cnt !== 32'd0) begin
      fails++;
      $display("FAIL reset_outputs got v%b b%b d%b ia %h ib %h cnt %0d want all 0",
               o_valid, o_busy, o_done, o_dut_ia, o_dut_ib, o_vec_cnt);
    end
    tick();
    reset = 1'b1;
    tick();
    tests++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_idle got busy %b valid %b want 0 0", o_busy, o_valid);
    end
  endtask

  task automatic test_start_stop();
    i_mode  = 2'd2;
    i_count = 32'd3;
    i_start = 1'b1;
    i_stop  = 1'b1;
    tick();
    i_start = 1'b0;
    i_stop  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_vec_cnt !== 32'd0) begin
        fails++;
        $display("FAIL start_stop_idle cyc %0d got busy %b valid %b cnt %0d want 0 0 0",
                 i, o_busy, o_valid, o_vec_cnt);
      end
      tick();
    end
  endtask

  task automatic test_mode1();
    int bad;
    bad = 0;
    begin_run(2'd1, 32'd64);
    for (int k = 0; k < 64; k++) begin
      logic [5:0] kk;
      kk = 6'(k);
      i_start = 1'b0;
      if (o_valid !== 1'b1 || o_dut_ia !== tbl[kk[5:3]] || o_dut_ib !== tbl[kk[2:0]]
          || o_vec_cnt !== 32'(k + 1)) begin
        bad++;
        $display("FAIL mode1_vec k=%0d got v%b %h %h cnt %0d want 1 %h %h %0d", k, o_valid,
                 o_dut_ia, o_dut_ib, o_vec_cnt, tbl[kk[5:3]], tbl[kk[2:0]], k + 1);
      end
      if (k == 9) begin
        tests++;
        if (o_dut_ia !== 32'd1 || o_dut_ib !== 32'd1) begin
          fails++;
          $display("FAIL mode1_k9 got %h %h want 1 1", o_dut_ia, o_dut_ib);
        end
      end
      if (k == 5) begin
        i_mode  = 2'd2;
        i_start = 1'b1;
      end
      if (k != 63) tick();
    end
    tests++;
    if (bad != 0) fails++;
    tests++;
    if (o_dut_ia !== 32'hAAAAAAAA || o_dut_ib !== 32'hAAAAAAAA) begin
      fails++;
      $display("FAIL mode1_k63 got %h %h want aaaaaaaa aaaaaaaa", o_dut_ia, o_dut_ib);
    end
    wait_done(9, "mode1");
    tests++;
    if (o_vec_cnt !== 32'd64 || o_dut_ia !== 32'hAAAAAAAA || o_dut_ib !== 32'hAAAAAAAA) begin
      fails++;
      $display("FAIL mode1_hold got cnt %0d %h %h want 64 aaaaaaaa aaaaaaaa",
               o_vec_cnt, o_dut_ia, o_dut_ib);
    end
  endtask

  task automatic test_mode2();
    begin_run(2'd2, 32'd3);
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (o_valid !== 1'b1 || o_dut_ia !== 32'(k) || o_dut_ib !== ~32'(k)) begin
        fails++;
        $display("FAIL mode2_vec k=%0d got v%b %h %h want 1 %h %h", k, o_valid,
                 o_dut_ia, o_dut_ib, 32'(k), ~32'(k));
      end
      if (k != 2) tick();
    end
    wait_done(9, "mode2");
    tests++;
    if (o_vec_cnt !== 32'd3) begin
      fails++;
      $display("FAIL mode2_cnt got %0d want 3", o_vec_cnt);
    end
  endtask

  task automatic test_mode3();
    int bad;
    logic [31:0] one;
    logic [31:0] ea, eb;
    bad = 0;
    one = 32'd1;
    begin_run(2'd3, 32'd33);
    for (int k = 0; k < 33; k++) begin
      ea = one << (k % 32);
      eb = one << ((k + 1) % 32);
      if (o_valid !== 1'b1 || o_dut_ia !== ea || o_dut_ib !== eb) begin
        bad++;
        $display("FAIL mode3_vec k=%0d got v%b %h %h want 1 %h %h", k, o_valid,
                 o_dut_ia, o_dut_ib, ea, eb);
      end
      if (k != 32) tick();
    end
    tests++;
    if (bad != 0) fails++;
    wait_done(9, "mode3");
  endtask

  task automatic test_mode0_stop();
    int bad;
    logic [31:0] ma, mb, la, lb;
    bad = 0;
    ma = SA;
    mb = SB;
    la = 0;
    lb = 0;
    begin_run(2'd0, 32'd0);
    for (int k = 0; k < 100; k++) begin
      if (o_valid !== 1'b1 || o_dut_ia !== ma || o_dut_ib !== mb) begin
        bad++;
        $display("FAIL mode0_vec k=%0d got v%b %h %h want 1 %h %h", k, o_valid,
                 o_dut_ia, o_dut_ib, ma, mb);
      end
      la = ma;
      lb = mb;
      ma = model_lfsr(ma);
      mb = model_lfsr(mb);
      if (k == 99) i_stop = 1'b1;
      tick();
      i_stop = 1'b0;
    end
    tests++;
    if (bad != 0) fails++;
    tests++;
    if (o_valid !== 1'b0 || o_vec_cnt !== 32'd100 || o_dut_ia !== la || o_dut_ib !== lb) begin
      fails++;
      $display("FAIL mode0_stop got v%b cnt %0d %h %h want 0 100 %h %h", o_valid,
               o_vec_cnt, o_dut_ia, o_dut_ib, la, lb);
    end
    wait_done(8, "mode0");
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    saw_done = 0;
    begin_run(2'd0, 32'd0);
    for (int k = 0; k < 10; k++) tick();
    tests++;
    if (o_valid !== 1'b1 || o_vec_cnt !== 32'd11) begin
      fails++;
      $display("FAIL midreset_pre got v%b cnt %0d want 1 11", o_valid, o_vec_cnt);
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({o_valid, o_busy, o_done} !== 3'b000 || o_dut_ia !== 32'd0 || o_dut_ib !== 32'd0
        || o_vec_cnt !== 32'd0) begin
      fails++;
      $display("FAIL midreset_outputs got v%b b%b d%b %h %h cnt %0d want all 0",
               o_valid, o_busy, o_done, o_dut_ia, o_dut_ib, o_vec_cnt);
    end
    for (int i = 0; i < 12; i++) begin
      if (i == 2) reset = 1'b1;
      tick();
      if (o_done !== 1'b0) saw_done = 1;
    end
    tests++;
    if (saw_done || o_busy !== 1'b0) begin
      fails++;
      $display("FAIL midreset_no_done got done %b busy %b want 0 0", saw_done, o_busy);
    end
    begin_run(2'd0, 32'd2);
    tests++;
    if (o_valid !== 1'b1 || o_dut_ia !== SA || o_dut_ib !== SB) begin
      fails++;
      $display("FAIL midreset_seed got v%b %h %h want 1 %h %h", o_valid, o_dut_ia, o_dut_ib, SA, SB);
    end
    tick();
    tests++;
    if (o_dut_ia !== model_lfsr(SA) || o_dut_ib !== model_lfsr(SB)) begin
      fails++;
      $display("FAIL midreset_step got %h %h want %h %h", o_dut_ia, o_dut_ib,
               model_lfsr(SA), model_lfsr(SB));
    end
    wait_done(9, "midreset");
  endtask

  task automatic test_event();
    int n_exp;
    int bad;
    bad = 0;
`ifdef STIM_HALT_ON_EVENT_EN
    n_exp = 20;
`else
    n_exp = 25;
`endif
    begin_run(2'd2, 32'd25);
    for (int k = 0; k < n_exp; k++) begin
      if (o_valid !== 1'b1 || o_dut_ia !== 32'(k)) begin
        bad++;
        $display("FAIL event_vec k=%0d got v%b %h want 1 %h", k, o_valid, o_dut_ia, 32'(k));
      end
      if (k == 19) i_event = 1'b1;
      tick();
      i_event = 1'b0;
    end
    tests++;
    if (bad != 0) fails++;
    tests++;
    if (o_valid !== 1'b0 || o_vec_cnt !== 32'(n_exp)) begin
      fails++;
      $display("FAIL event_end got v%b cnt %0d want 0 %0d", o_valid, o_vec_cnt, n_exp);
    end
    wait_done(8, "event");
  endtask

  initial begin
    test_reset();
    test_start_stop();
    test_mode1();
    test_mode2();
    test_mode3();
    test_mode0_stop();
    test_reset_mid();
    test_event();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stim_gen.md
STIM_GEN -- requirements
Module: stim_gen

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand width; only 32 supported.
REQ-002 SHALL provide parameter SEED_A, default 32'hACE12468, LFSR A seed, nonzero.
REQ-003 SHALL provide parameter SEED_B, default 32'h1357BDF0, LFSR B seed, nonzero.
REQ-004 SHALL provide parameter DRAIN_CYCLES, default 8, quiet cycles after last vector, >=1.
REQ-005 SHALL provide port clk  input  1  sole clock, rising edge.
REQ-006 SHALL provide port reset  input  1  asynchronous active-low reset.
REQ-007 SHALL provide port i_start  input  1  begin run.
REQ-008 SHALL provide port i_stop  input  1  abort run.
REQ-009 SHALL provide port i_mode  input  2  pattern select.
REQ-010 SHALL provide port i_count  input  32  vectors per run; 0 = unbounded.
REQ-011 SHALL provide port i_event  input  1  mismatch pulse from monitor.
REQ-012 SHALL provide port o_dut_ia  output  WIDTH  operand A to DUT and monitor.
REQ-013 SHALL provide port o_dut_ib  output  WIDTH  operand B to DUT and monitor.
REQ-014 SHALL provide port o_valid  output  1  new vector this cycle.
REQ-015 SHALL provide port o_busy  output  1  high in RUN or DRAIN.
REQ-016 SHALL provide port o_done  output  1  one-cycle pulse on entry to DONE.
REQ-017 SHALL provide port o_vec_cnt  output  32  vectors issued this run.

Function
REQ-018 SHALL implement FSM IDLE, RUN, DRAIN, DONE: IDLE/DONE->RUN on i_start; RUN->DRAIN on count reached, i_stop or halt; DRAIN->DONE after DRAIN_CYCLES cycles; DONE holds until i_start.
REQ-019 SHALL latch i_mode and i_count on the start edge; changes during a run ignored.
REQ-020 SHALL issue one vector per clock in RUN (o_valid=1), first vector in the cycle after i_start is sampled; vector index k starts at 0.
REQ-021 SHALL leave RUN after exactly i_count vectors (i_count!=0); i_count=0 runs until i_stop or halt.
REQ-022 SHALL increment o_vec_cnt per vector, saturating at 32'hFFFFFFFF; clear on start edge; hold through DRAIN/DONE.
REQ-023 Mode 0: two Galois LFSRs, polynomial x^32+x^22+x^2+x+1; vector k=0 is (SEED_A, SEED_B); each LFSR advances once per vector; no reseed on start.
REQ-024 Mode 1: table T={0, 1, 7FFFFFFF, 80000000, FFFFFFFF, FFFFFFFE, 55555555, AAAAAAAA}; ia=T[k[5:3]], ib=T[k[2:0]]; wraps every 64.
REQ-025 Mode 2: ia=k, ib=~k (mod 2^32).
REQ-026 Mode 3: ia=1<<(k mod 32), ib=1<<((k+1) mod 32).
REQ-027 Outside RUN: o_valid=0; o_dut_ia/ib hold last issued vector.
REQ-028 i_stop sampled high in RUN: next cycle DRAIN, no further vectors; i_stop ignored in other states.
REQ-029 i_start in RUN/DRAIN ignored; i_start and i_stop together in IDLE/DONE: stop wins, no run.
REQ-030 o_done SHALL go high DRAIN_CYCLES+1 cycles after the last o_valid cycle.

Reset
REQ-031 reset low SHALL asynchronously force IDLE, all outputs 0, LFSRs to seeds, counters 0.
REQ-032 Reset mid-run SHALL abort without o_done; operation resumes on first rising edge after release.

Configuration
REQ-033 With STIM_HALT_ON_EVENT_EN defined, i_event sampled high in RUN SHALL act as i_stop (vector issued that cycle counted); DRAIN/DONE follow normally.
REQ-034 Without STIM_HALT_ON_EVENT_EN, i_event SHALL have no effect; port remains present.

Verification
REQ-035 Mode 1, count 64 -> 64 o_valid cycles; k=9 gives (1,1); k=63 gives (AAAAAAAA,AAAAAAAA); o_done 9 cycles after last vector.
REQ-036 Mode 2, count 3 -> (0,FFFFFFFF),(1,FFFFFFFE),(2,FFFFFFFD); o_vec_cnt=3; o_busy low with o_done.
REQ-037 Mode 0, count 0, i_stop sampled with vector 99 -> o_vec_cnt=100; vectors match software LFSR model from seeds.
REQ-038 reset low at vector 10 -> outputs 0 immediately, no o_done; restart in mode 0 reproduces (SEED_A, SEED_B).
REQ-039 Macro defined, i_event high with vector 19 -> o_valid low next cycle, o_vec_cnt=20; macro undefined -> full count issued.
REQ-040 i_start and i_stop high together in IDLE -> stays IDLE, o_busy=0, o_valid=0.
